// File: rtl/magnetron_control_pkg.sv
// Shared definitions for the magnetron enable controller: state encoding and
// the levels every conditioned input returns to while reset is asserted.
package magnetron_control_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      COOK = 1'b1
   } state_t;

   localparam logic BUTTON_INACTIVE = 1'b1;
   localparam logic DOOR_INACTIVE   = 1'b0;
   localparam logic TIMER_INACTIVE  = 1'b0;

endpackage

// File: rtl/magnetron_control_input_conditioner.sv
// Multi-stage synchronizer for one asynchronous input, followed by an optional
// debounce filter that accepts a new level only after it has been stable long enough.
module input_conditioner #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 0,
   parameter logic RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   logic [SYNC_STAGES-1:0] sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= {SYNC_STAGES{RESET_LEVEL}};
      else       sync <= {sync[SYNC_STAGES-2:0], raw};
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign level = sync[SYNC_STAGES-1];
      end else begin : g_debounce
         localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
         localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] count;
         logic          accepted;

         // Down-counter reloads on any cycle the synchronized level agrees with
         // the accepted one, so a single bounce restarts the stability window.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               count    <= RELOAD;
               accepted <= RESET_LEVEL;
            end else if (sync[SYNC_STAGES-1] == accepted) begin
               count    <= RELOAD;
            end else if (count == '0) begin
               accepted <= sync[SYNC_STAGES-1];
               count    <= RELOAD;
            end else begin
               count    <= count - 1'b1;
            end
         end

         assign level = accepted;
      end
   endgenerate

endmodule

// File: rtl/magnetron_control.sv
// Magnetron enable controller: conditions the panel/interlock inputs and runs a
// two-state cook FSM whose state register directly drives mag_on.
//
// state | meaning
// IDLE  | magnetron off, waiting for a start press with no stop cause
// COOK  | magnetron on until any stop cause appears
module magnetron_control
   import magnetron_control_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic startn,
   input  logic stopn,
   input  logic clearn,
   input  logic door_closed,
   input  logic timer_done,
   output logic mag_on
);

   logic start_level, stop_level, clear_level, door_level, timer_level;
   logic start_prev, start_event, stop_cond;
   state_t state, state_next;

   input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                       .RESET_LEVEL(BUTTON_INACTIVE))
      u_start (.clk(clk), .reset(reset), .raw(startn), .level(start_level));

   input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                       .RESET_LEVEL(BUTTON_INACTIVE))
      u_stop (.clk(clk), .reset(reset), .raw(stopn), .level(stop_level));

   input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                       .RESET_LEVEL(BUTTON_INACTIVE))
      u_clear (.clk(clk), .reset(reset), .raw(clearn), .level(clear_level));

   // Interlock inputs skip the debounce so a door opening stops cooking fastest.
   input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0),
                       .RESET_LEVEL(DOOR_INACTIVE))
      u_door (.clk(clk), .reset(reset), .raw(door_closed), .level(door_level));

   input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0),
                       .RESET_LEVEL(TIMER_INACTIVE))
      u_timer (.clk(clk), .reset(reset), .raw(timer_done), .level(timer_level));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) start_prev <= BUTTON_INACTIVE;
      else       start_prev <= start_level;
   end

   assign start_event = start_prev & ~start_level;
   assign stop_cond   = ~stop_level | ~clear_level | ~door_level | timer_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_event && !stop_cond) state_next = COOK;
         COOK: if (stop_cond)                 state_next = IDLE;
         default:                             state_next = IDLE;
      endcase
   end

   assign mag_on = (state == COOK);

endmodule

// File: tb/tb_magnetron_control.sv
// Bench for magnetron_control: two instances (no debounce, 4-cycle debounce)
// share one stimulus stream and are compared every cycle against a delay-line model.
module tb_magnetron_control;

   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b0, timer_done = 1'b0;
   logic mag_on_db0, mag_on_db4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   magnetron_control #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .startn(startn), .stopn(stopn), .clearn(clearn),
      .door_closed(door_closed), .timer_done(timer_done), .mag_on(mag_on_db0));

   magnetron_control #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .startn(startn), .stopn(stopn), .clearn(clearn),
      .door_closed(door_closed), .timer_done(timer_done), .mag_on(mag_on_db4));

   // ---------------- behavioural model ----------------
   // Index d: 0 -> no debounce, 1 -> 4-cycle debounce. Input i: start, stop, clear, door, timer.
   logic [SYNC-1:0] pipe [2][5];
   logic            acc  [2][5];
   int              run  [2][5];
   logic            prev_start [2];
   logic            cooking    [2];

   function automatic int db_of(input int d);
      return (d == 0) ? 0 : 4;
   endfunction

   function automatic logic idle_level(input int i);
      return (i < 3) ? 1'b1 : 1'b0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 5; i++) begin
            pipe[d][i] = {SYNC{idle_level(i)}};
            acc[d][i]  = idle_level(i);
            run[d][i]  = 0;
         end
         prev_start[d] = 1'b1;
         cooking[d]    = 1'b0;
      end
   endtask

   function automatic logic cond(input int d, input int i);
      if (i < 3 && db_of(d) > 0) return acc[d][i];
      return pipe[d][i][SYNC-1];
   endfunction

   task automatic model_step();
      logic [4:0] raw;
      logic ev, stop, so;
      raw = {timer_done, door_closed, clearn, stopn, startn};
      for (int d = 0; d < 2; d++) begin
         ev   = prev_start[d] & ~cond(d, 0);
         stop = ~cond(d, 1) | ~cond(d, 2) | ~cond(d, 3) | cond(d, 4);
         if (stop)    cooking[d] = 1'b0;
         else if (ev) cooking[d] = 1'b1;
         prev_start[d] = cond(d, 0);
         for (int i = 0; i < 5; i++) begin
            so = pipe[d][i][SYNC-1];
            if (i < 3 && db_of(d) > 0) begin
               if (so != acc[d][i]) begin
                  run[d][i] = run[d][i] + 1;
                  if (run[d][i] == db_of(d)) begin
                     acc[d][i] = so;
                     run[d][i] = 0;
                  end
               end else begin
                  run[d][i] = 0;
               end
            end
            pipe[d][i] = {pipe[d][i][SYNC-2:0], raw[i]};
         end
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("model_db0", mag_on_db0, cooking[0]);
         check("model_db4", mag_on_db4, cooking[1]);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int n);
      startn = 1'b0;
      cycles(n);
      startn = 1'b1;
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      check("reset_db0", mag_on_db0, 1'b0);
      check("reset_db4", mag_on_db4, 1'b0);
      cycles(3);
      reset = 1'b0;
      cycles(6);
      check("idle_db0", mag_on_db0, 1'b0);
      check("idle_db4", mag_on_db4, 1'b0);

      // start with door open, then close door while start still held
      press(6);
      startn = 1'b0;
      cycles(10);
      check("door_open_start", mag_on_db4 | mag_on_db0, 1'b0);
      door_closed = 1'b1;
      cycles(12);
      check("held_start_no_cook_db0", mag_on_db0, 1'b0);
      check("held_start_no_cook_db4", mag_on_db4, 1'b0);
      startn = 1'b1;
      cycles(12);

      // single-cycle press: cook on edge SYNC+1 for the undebounced instance
      startn = 1'b0;
      cycles(1);
      startn = 1'b1;
      cycles(1);
      check("start_lat_edge2", mag_on_db0, 1'b0);
      cycles(1);
      check("start_lat_edge3", mag_on_db0, 1'b1);
      check("short_press_db4", mag_on_db4, 1'b0);
      cycles(5);
      check("cook_holds", mag_on_db0, 1'b1);
      timer_done = 1'b1;
      cycles(2);
      check("timer_lat_edge2", mag_on_db0, 1'b1);
      cycles(1);
      check("timer_lat_edge3", mag_on_db0, 1'b0);
      timer_done = 1'b0;
      cycles(6);
      check("timer_fall_stays_off", mag_on_db0, 1'b0);

      // 5-cycle press on debounced instance: cooks on edge 2+4+1
      startn = 1'b0;
      cycles(5);
      startn = 1'b1;
      cycles(1);
      check("db4_edge6", mag_on_db4, 1'b0);
      cycles(1);
      check("db4_edge7", mag_on_db4, 1'b1);
      stopn = 1'b0;
      cycles(8);
      check("stop_db0", mag_on_db0, 1'b0);
      check("stop_db4", mag_on_db4, 1'b0);
      stopn = 1'b1;
      cycles(10);

      // 2-cycle glitch: too short for the debounced instance
      press(2);
      cycles(10);
      check("glitch_db4", mag_on_db4, 1'b0);
      check("glitch_db0", mag_on_db0, 1'b1);
      clearn = 1'b0;
      cycles(8);
      check("clear_db0", mag_on_db0, 1'b0);
      clearn = 1'b1;
      cycles(10);

      // door opening stops both instances in SYNC+1 edges
      press(6);
      cycles(10);
      check("recook_db4", mag_on_db4, 1'b1);
      door_closed = 1'b0;
      cycles(3);
      check("door_stop_db0", mag_on_db0, 1'b0);
      check("door_stop_db4", mag_on_db4, 1'b0);
      door_closed = 1'b1;
      cycles(10);

      // stop/clear held dominate a start press
      clearn = 1'b0;
      cycles(8);
      press(6);
      cycles(10);
      check("clear_priority", mag_on_db0 | mag_on_db4, 1'b0);
      clearn = 1'b1;
      cycles(10);
      check("clear_release_no_cook", mag_on_db0 | mag_on_db4, 1'b0);
      stopn = 1'b0;
      cycles(8);
      press(6);
      cycles(10);
      check("stop_priority", mag_on_db0 | mag_on_db4, 1'b0);
      stopn = 1'b1;
      cycles(10);
      check("stop_release_no_cook", mag_on_db0 | mag_on_db4, 1'b0);

      // asynchronous reset mid-cook
      press(6);
      cycles(10);
      check("precook_reset", mag_on_db0 & mag_on_db4, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_db0", mag_on_db0, 1'b0);
      check("async_reset_db4", mag_on_db4, 1'b0);
      cycles(2);
      reset = 1'b0;
      cycles(4);

      // randomized stimulus
      for (int k = 0; k < 1500; k++) begin
         startn      = ($urandom_range(0, 1) == 0);
         stopn       = ($urandom_range(0, 7) != 0);
         clearn      = ($urandom_range(0, 9) != 0);
         door_closed = ($urandom_range(0, 7) != 0);
         timer_done  = ($urandom_range(0, 9) == 0);
         cycles($urandom_range(1, 8));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
